pq_client: RTL and testbench
============================

# pq_client

Issue-side controller for the register-array max priority queue. It converts a valid/ready insert stream and a valid/ready extract stream into the queue's write/read/replace strobes. After every queue operation it enforces a fixed settle interval, so the extract stream only presents a queue top that has finished sorting. It also provides a flush command that drains and discards all queued entries.

## Interface
- QUEUE_SIZE, 4, capacity of the attached queue
- DATA_WIDTH, 16, entry width
- SETTLE_CYCLES, QUEUE_SIZE/2, idle cycles required after any queue operation before the top is valid; 0 allowed
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- s_valid  in  1  insert request
- s_ready  out  1  insert accepted when s_valid && s_ready
- s_data  in  DATA_WIDTH  entry to insert
- m_valid  out  1  current maximum available
- m_ready  in  1  extract accepted when m_valid && m_ready
- m_data  out  DATA_WIDTH  current maximum; equals q_top
- i_flush  in  1  request a drain of all entries (level-sampled in IDLE)
- o_busy  out  1  state != IDLE
- o_flushed  out  $clog2(QUEUE_SIZE+1)  entries discarded by the most recent flush
- q_wrt  out  1  queue write strobe
- q_read  out  1  queue read strobe (both strobes high = replace)
- q_data  out  DATA_WIDTH  queue write data; equals s_data
- q_full  in  1  queue full
- q_empty  in  1  queue empty
- q_top  in  DATA_WIDTH  queue head

## Operation
- States: IDLE, WAIT, FLUSH. Settle counter width is $clog2(SETTLE_CYCLES+1).
- IDLE with i_flush=1:
  - s_ready=0, m_valid=0, no strobes in this cycle.
  - Clear o_flushed to 0 and go to FLUSH.
- IDLE with i_flush=0:
  - m_valid = !q_empty.
  - s_ready = !q_full || (m_valid && m_ready).
  - ins = s_valid && s_ready; ext = m_valid && m_ready.
  - ins && ext: replace. q_wrt=1, q_read=1. Both handshakes complete in the same cycle.
  - ins only: q_wrt=1. ext only: q_read=1.
  - After any strobe: if SETTLE_CYCLES>0, load cnt=SETTLE_CYCLES and go to WAIT; otherwise stay in IDLE.
- WAIT:
  - s_ready=0, m_valid=0, strobes 0.
  - cnt decrements each cycle. When cnt==1, go to IDLE, so WAIT lasts exactly SETTLE_CYCLES cycles.
  - i_flush is ignored in WAIT; a flush held high is taken on the next IDLE cycle.
- FLUSH:
  - s_ready=0, m_valid=0, q_wrt=0.
  - q_read = !q_empty. Each asserted q_read increments o_flushed.
  - When q_empty=1: go to WAIT (cnt=SETTLE_CYCLES), or to IDLE if SETTLE_CYCLES=0.
- Invariants:
  - q_read is never asserted while q_empty=1.
  - q_wrt is never asserted while q_full=1 unless q_read is also asserted.
  - q_wrt/q_read are combinational from the handshakes; q_data = s_data.
- The client does not reset the queue. Integration drives the queue reset from the same reset event.

## Timing
- Reset: state=IDLE, cnt=0, o_flushed=0, o_busy=0. Outputs m_valid, s_ready, q_wrt and q_read follow the IDLE equations from the next cycle.
- Strobe-to-next-strobe spacing is SETTLE_CYCLES+1 cycles for back-to-back traffic.
- Flush of N entries: N FLUSH cycles with q_read=1, plus 1 cycle observing q_empty, plus SETTLE_CYCLES WAIT cycles.
- RST asserted mid-WAIT or mid-FLUSH: next cycle is IDLE, o_flushed=0, no strobe in the reset cycle.
- Replace on a full queue is legal; occupancy is unchanged.

## Test plan
- Insert sequence, then extract: QUEUE_SIZE=4, SETTLE=2; insert 5, 9, 3 back to back.
  - q_wrt pulses at cycles 0, 3, 6.
  - m_valid=1 at cycle 9 with m_data=9.
  - Extracts then return 9, 5, 3, each spaced 3 cycles apart.
- Full backpressure: queue filled with 4 entries and m_ready=0.
  - s_ready=0 and q_wrt never pulses, even while s_valid=1.
  - Raising m_ready gives a replace: q_wrt=q_read=1 in one cycle.
- Replace ordering: queue holds {8, 2}; s_data=6 and m_ready=1 in the same IDLE cycle.
  - m_data=8 is accepted and 6 is written.
  - After settle, m_data=6.
- Empty extract: queue empty, m_ready=1.
  - m_valid=0 and q_read never asserted.
- Flush: queue holds 3 entries; pulse i_flush in IDLE.
  - 3 consecutive q_read cycles, then q_empty.
  - o_flushed=3, then 2 WAIT cycles, then IDLE with m_valid=0.
- Reset mid-WAIT: RST=1 during cycle 1 of WAIT.
  - Next cycle: o_busy=0, o_flushed=0, no strobes.
  - s_ready follows q_full.

Source files
------------

// File: rtl/pq_client.sv
// pq_client: valid/ready issue controller for a register-array max priority queue with settle and flush
module pq_client #(
    parameter int QUEUE_SIZE    = 4,
    parameter int DATA_WIDTH    = 16,
    parameter int SETTLE_CYCLES = QUEUE_SIZE / 2
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [DATA_WIDTH-1:0]           s_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [DATA_WIDTH-1:0]           m_data,
    input  logic                            i_flush,
    output logic                            o_busy,
    output logic [$clog2(QUEUE_SIZE+1)-1:0] o_flushed,
    output logic                            q_wrt,
    output logic                            q_read,
    output logic [DATA_WIDTH-1:0]           q_data,
    input  logic                            q_full,
    input  logic                            q_empty,
    input  logic [DATA_WIDTH-1:0]           q_top
);
    localparam int CW = SETTLE_CYCLES > 0 ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int FW = $clog2(QUEUE_SIZE + 1);
    localparam logic [CW-1:0] SETTLE = CW'(SETTLE_CYCLES);
    localparam bit HAS_WAIT = SETTLE_CYCLES > 0;

    typedef enum logic [1:0] {IDLE, WAIT, FLUSH} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [FW-1:0] flushed_n;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            o_flushed <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            o_flushed <= flushed_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        flushed_n = o_flushed;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        q_wrt     = 1'b0;
        q_read    = 1'b0;
        case (state)
            IDLE: begin
                if (i_flush) begin
                    flushed_n = '0;
                    state_n   = FLUSH;
                end else begin
                    m_valid = !q_empty;
                    s_ready = !q_full || (m_valid && m_ready);
                    q_wrt   = s_valid && s_ready;
                    q_read  = m_valid && m_ready;
                    if ((q_wrt || q_read) && HAS_WAIT) begin
                        cnt_n   = SETTLE;
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_n   = cnt - CW'(1);
                state_n = cnt <= CW'(1) ? IDLE : WAIT;
            end
            FLUSH: begin
                q_read = !q_empty;
                if (!q_empty) begin
                    flushed_n = o_flushed + FW'(1);
                end else begin
                    cnt_n   = SETTLE;
                    state_n = HAS_WAIT ? WAIT : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // the queue is reset by the same event, so nothing may be issued in a reset cycle
        if (RST) begin
            s_ready = 1'b0;
            m_valid = 1'b0;
            q_wrt   = 1'b0;
            q_read  = 1'b0;
        end
    end

    assign o_busy = state != IDLE;
    assign m_data = q_top;
    assign q_data = s_data;
endmodule

// File: tb/tb_pq_client.sv
// tb_pq_client: table vectors, corner sequences and random traffic against a queue-level reference model
module tb_pq_client;
    localparam int QS = 4;
    localparam int DW = 16;
    localparam int ST = 2;
    localparam int FW = $clog2(QS + 1);

    logic          CLK = 1'b0;
    logic          RST, s_valid, s_ready, m_valid, m_ready, i_flush, o_busy;
    logic          q_wrt, q_read, q_full, q_empty;
    logic [DW-1:0] s_data, m_data, q_data, q_top;
    logic [FW-1:0] o_flushed;

    pq_client #(.QUEUE_SIZE(QS), .DATA_WIDTH(DW), .SETTLE_CYCLES(ST)) dut (
        .CLK(CLK), .RST(RST), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .i_flush(i_flush),
        .o_busy(o_busy), .o_flushed(o_flushed), .q_wrt(q_wrt), .q_read(q_read),
        .q_data(q_data), .q_full(q_full), .q_empty(q_empty), .q_top(q_top)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit sv;
        int sd;
        bit mr;
        bit w;
        bit r;
        bit mv;
        int md;
    } vec_t;

    int   errors = 0, checks = 0, cyc = 0, idle_at = 0, flushed = 0;
    bit   flushing = 0, armed = 0;
    int   qd[$];
    logic sm_sr, sm_mv, sm_w, sm_r, sm_busy;
    int   sm_md, sm_fl;
    vec_t tv[20];

    function automatic int qmax();
        int m = 0;
        foreach (qd[i]) if (qd[i] > m) m = qd[i];
        return m;
    endfunction

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0d expected %0d", n, cyc, act, exp);
        end
    endtask

    // one clock: drive inputs, compare against the model, then advance model and queue at the edge
    task automatic cycle(input bit rst, input bit sv, input int sd, input bit mr, input bit fl);
        bit idle, e_sr, e_mv, e_w, e_r;
        int m;
        RST = rst; s_valid = sv; s_data = DW'(sd); m_ready = mr; i_flush = fl;
        q_full = qd.size() >= QS; q_empty = qd.size() == 0; q_top = DW'(qmax());
        #1;
        sm_sr = s_ready; sm_mv = m_valid; sm_w = q_wrt; sm_r = q_read; sm_busy = o_busy;
        sm_md = int'(m_data); sm_fl = int'(o_flushed);
        idle = !flushing && cyc >= idle_at;
        e_sr = 0; e_mv = 0; e_w = 0; e_r = 0;
        if (!rst) begin
            if (flushing) e_r = qd.size() > 0;
            else if (idle && !fl) begin
                e_mv = qd.size() > 0;
                e_sr = qd.size() < QS || (e_mv && mr);
                e_w  = sv && e_sr;
                e_r  = e_mv && mr;
            end
        end
        chk("s_ready", sm_sr, e_sr);
        chk("m_valid", sm_mv, e_mv);
        chk("q_wrt", sm_w, e_w);
        chk("q_read", sm_r, e_r);
        chk("m_data", sm_md, qmax());
        chk("q_data", int'(q_data), sd);
        if (armed) begin
            chk("o_busy", sm_busy, !idle);
            chk("o_flushed", sm_fl, flushed);
        end
        @(posedge CLK);
        if (rst) begin
            qd.delete();
            flushing = 0; flushed = 0; idle_at = cyc + 1; armed = 1;
        end else begin
            if (e_r) begin
                m = qmax();
                for (int i = 0; i < qd.size(); i++) if (qd[i] == m) begin qd.delete(i); break; end
            end
            if (e_w) qd.push_back(sd);
            if (flushing) begin
                if (e_r) flushed++;
                else begin flushing = 0; idle_at = cyc + 1 + ST; end
            end else if (idle && fl) begin
                flushing = 1; flushed = 0;
            end else if (e_w || e_r) idle_at = cyc + 1 + ST;
        end
        cyc++;
        @(negedge CLK);
    endtask

    task automatic idle_n(input int n);
        repeat (n) cycle(0, 0, 0, 0, 0);
    endtask

    task automatic ins(input int d);
        cycle(0, 1, d, 0, 0);
        idle_n(ST);
    endtask

    initial begin
        int reads;
        RST = 1; s_valid = 0; s_data = 0; m_ready = 0; i_flush = 0;
        q_full = 0; q_empty = 1; q_top = 0;
        for (int i = 0; i < 20; i++) tv[i] = '{0, 0, 1, 0, 0, 0, 0};
        tv[0] = '{1, 5, 0, 1, 0, 0, 0};
        tv[1] = '{1, 9, 0, 0, 0, 0, 0};
        tv[2] = '{1, 9, 0, 0, 0, 0, 0};
        tv[3] = '{1, 9, 0, 1, 0, 1, 5};
        tv[4] = '{1, 3, 0, 0, 0, 0, 0};
        tv[5] = '{1, 3, 0, 0, 0, 0, 0};
        tv[6] = '{1, 3, 0, 1, 0, 1, 9};
        tv[9] = '{0, 0, 1, 0, 1, 1, 9};
        tv[12] = '{0, 0, 1, 0, 1, 1, 5};
        tv[15] = '{0, 0, 1, 0, 1, 1, 3};
        @(negedge CLK);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        chk("reset_busy", sm_busy, 0);
        chk("reset_flushed", sm_fl, 0);
        cycle(0, 0, 0, 0, 0);
        chk("reset_sready", sm_sr, 1);

        for (int i = 0; i < 20; i++) begin
            cycle(0, tv[i].sv, tv[i].sd, tv[i].mr, 0);
            chk("tbl_wrt", sm_w, tv[i].w);
            chk("tbl_read", sm_r, tv[i].r);
            chk("tbl_mvalid", sm_mv, tv[i].mv);
            if (tv[i].mv) chk("tbl_mdata", sm_md, tv[i].md);
        end

        cycle(1, 0, 0, 0, 0);
        ins(10); ins(20); ins(30); ins(40);
        repeat (3) begin
            cycle(0, 1, 50, 0, 0);
            chk("full_sready", sm_sr, 0);
            chk("full_wrt", sm_w, 0);
        end
        cycle(0, 1, 50, 1, 0);
        chk("repl_full_wrt", sm_w, 1);
        chk("repl_full_read", sm_r, 1);
        chk("repl_full_md", sm_md, 40);
        idle_n(ST);
        cycle(0, 1, 60, 0, 0);
        chk("repl_full_still_full", sm_sr, 0);
        chk("repl_full_top", sm_md, 50);

        cycle(1, 0, 0, 0, 0);
        ins(8); ins(2);
        cycle(0, 1, 6, 1, 0);
        chk("repl_md", sm_md, 8);
        chk("repl_wrt", sm_w, 1);
        chk("repl_read", sm_r, 1);
        idle_n(ST);
        cycle(0, 0, 0, 0, 0);
        chk("repl_next_mv", sm_mv, 1);
        chk("repl_next_md", sm_md, 6);

        cycle(1, 0, 0, 0, 0);
        repeat (3) begin
            cycle(0, 0, 0, 1, 0);
            chk("empty_mvalid", sm_mv, 0);
            chk("empty_read", sm_r, 0);
        end

        ins(4); ins(11); ins(7);
        cycle(0, 1, 99, 1, 1);
        chk("flush_start_wrt", sm_w, 0);
        chk("flush_start_read", sm_r, 0);
        reads = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(0, 0, 0, 0, 0);
            if (!sm_r) break;
            reads++;
        end
        chk("flush_reads", reads, 3);
        chk("flush_count", sm_fl, 3);
        chk("flush_busy_empty", sm_busy, 1);
        cycle(0, 0, 0, 0, 0);
        chk("flush_wait1", sm_busy, 1);
        cycle(0, 0, 0, 0, 0);
        chk("flush_wait2", sm_busy, 1);
        cycle(0, 0, 0, 0, 0);
        chk("flush_idle", sm_busy, 0);
        chk("flush_idle_mv", sm_mv, 0);
        chk("flush_kept", sm_fl, 3);

        cycle(0, 1, 7, 0, 0);
        cycle(1, 1, 8, 0, 0);
        chk("rst_wait_wrt", sm_w, 0);
        chk("rst_wait_busy_before", sm_busy, 1);
        cycle(0, 0, 0, 0, 0);
        chk("rst_wait_busy", sm_busy, 0);
        chk("rst_wait_flushed", sm_fl, 0);
        chk("rst_wait_sready", sm_sr, 1);

        ins(1); ins(2);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        chk("rst_flush_read_pre", sm_r, 1);
        cycle(1, 0, 0, 0, 0);
        chk("rst_flush_read", sm_r, 0);
        cycle(0, 0, 0, 0, 0);
        chk("rst_flush_busy", sm_busy, 0);
        chk("rst_flush_count", sm_fl, 0);

        repeat (3000)
            cycle($urandom_range(63) == 0, $urandom_range(1), int'($urandom_range(65535)),
                  $urandom_range(1), $urandom_range(15) == 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
